wb_master_single: RTL and testbench



---
 rtl/wb_master_pkg.sv | 27 ++
 rtl/wb_timeout_counter.sv | 31 +++
 rtl/wb_master_single.sv | 144 ++++++++++++++
 tb/tb_wb_master_single.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_master_pkg.sv
// Shared types and helpers for the single-transfer Wishbone initiator.
// The state enum is kept separate from the global state_t so the names cannot clash.
package wb_master_pkg;

    typedef enum logic [1:0] {
        WBM_IDLE   = 2'd0,
        WBM_ACTIVE = 2'd1,
        WBM_DONE   = 2'd2
    } wbm_state_t;

    localparam int SEL_MAX = 8;

    // Mask that keeps only the select lanes the data port actually has.
    function automatic logic [SEL_MAX-1:0] sel_mask(input int used);
        logic [SEL_MAX-1:0] m;
        m = '0;
        for (int i = 0; i < SEL_MAX; i++) begin
            if (i < used) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Cycle counter that flags when a bus wait reaches TIMEOUT cycles.
// A TIMEOUT of 0 means the counter never expires.
module wb_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [CW-1:0] count_r;

    // Wait-cycle counter: cleared when a cycle starts, advanced while waiting.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable) begin
            count_r <= count_r + CW'(1);
        end
    end

    assign expired = (TIMEOUT != 0) ? (count_r == LAST) : 1'b0;

endmodule

// File: rtl/wb_master_single.sv
// Wishbone B4 classic initiator: one READ or WRITE bus cycle per accepted command,
// answered by a one-cycle response strobe carrying read data or an error flag.
module wb_master_single
    import wb_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int GRANULE    = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
    input  logic [DATA_WIDTH-1:0] cmd_dat_i,
    input  logic [SEL_MAX-1:0]    cmd_sel_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_dat_o,
    output logic                  rsp_err_o,
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [SEL_MAX-1:0]    sel_o,
    output logic                  we_o,
    output logic                  stb_o,
    output logic                  cyc_o,
    input  logic                  ack_i,
    input  logic                  err_i
);

    localparam int SEL_USED = DATA_WIDTH / GRANULE;
    localparam logic [SEL_MAX-1:0] SEL_MASK = sel_mask(SEL_USED);

    localparam logic [1:0] ST_IDLE   = 2'(WBM_IDLE);
    localparam logic [1:0] ST_ACTIVE = 2'(WBM_ACTIVE);
    localparam logic [1:0] ST_DONE   = 2'(WBM_DONE);

    logic [1:0] state_r;
    logic [1:0] state_s;
    logic       accept_s;
    logic       ack_ok_s;
    logic       fail_s;
    logic       finish_s;
    logic       count_en_s;
    logic       expired_s;

    assign cmd_ready_o = (state_r == ST_IDLE);
    assign accept_s    = cmd_valid_i & cmd_ready_o;
    assign finish_s    = ack_ok_s | fail_s;

    // Next state; err_i outranks ack_i, and both outrank the timeout.
    always_comb begin
        state_s    = state_r;
        ack_ok_s   = 1'b0;
        fail_s     = 1'b0;
        count_en_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_ACTIVE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (err_i) begin
                    fail_s  = 1'b1;
                    state_s = ST_DONE;
                end else if (ack_i) begin
                    ack_ok_s = 1'b1;
                    state_s  = ST_DONE;
                end else if (expired_s) begin
                    fail_s  = 1'b1;
                    state_s = ST_DONE;
                end else begin
                    count_en_s = 1'b1;
                    state_s    = ST_ACTIVE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    wb_timeout_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clear  (accept_s),
        .enable (count_en_s),
        .expired(expired_s)
    );

    // State register and bus-side outputs; command fields are frozen for the whole cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            cyc_o   <= 1'b0;
            stb_o   <= 1'b0;
            we_o    <= 1'b0;
            adr_o   <= '0;
            dat_o   <= '0;
            sel_o   <= '0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                cyc_o <= 1'b1;
                stb_o <= 1'b1;
                we_o  <= cmd_we_i;
                adr_o <= cmd_adr_i;
                dat_o <= cmd_dat_i;
                sel_o <= cmd_sel_i & SEL_MASK;
            end else if (finish_s) begin
                cyc_o <= 1'b0;
                stb_o <= 1'b0;
            end
        end
    end

    // Response outputs; data and status hold until the next response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_dat_o   <= '0;
        end else begin
            rsp_valid_o <= finish_s;
            if (finish_s) begin
                rsp_err_o <= fail_s;
            end
            if (ack_ok_s && !we_o) begin
                rsp_dat_o <= dat_i;
            end
        end
    end

endmodule

// File: tb/tb_wb_master_single.sv
// Bench for wb_master_single: randomized commands against a scripted slave,
// checked every cycle by a transaction-level model, plus a few literal expectations.
module tb_wb_master_single;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_we_i = 1'b0;
    logic [15:0] cmd_adr_i = 16'h0000;
    logic [31:0] cmd_dat_i = 32'h0000_0000;
    logic [7:0]  cmd_sel_i = 8'h00;
    logic        rsp_valid_o;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic [15:0] adr_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i = 32'h0000_0000;
    logic [7:0]  sel_o;
    logic        we_o;
    logic        stb_o;
    logic        cyc_o;
    logic        ack_i = 1'b0;
    logic        err_i = 1'b0;

    int n_checks = 0;
    int n_pass = 0;

    // Slave plan: kind 0=ack, 1=err (ack random), 2=err+ack, 3=silent; k = ACTIVE cycle of the reply.
    int p_kind = 0;
    int p_k = 1;
    int a_kind = 3;
    int a_k = 1;

    logic [31:0] s_mem [16];
    logic [31:0] m_mem [16];

    wb_master_single #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(32),
        .GRANULE(8),
        .TIMEOUT(TO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_we_i(cmd_we_i), .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
        .rsp_valid_o(rsp_valid_o), .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
        .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .sel_o(sel_o),
        .we_o(we_o), .stb_o(stb_o), .cyc_o(cyc_o), .ack_i(ack_i), .err_i(err_i)
    );

    initial begin
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Scripted slave: replies on the a_k-th strobed cycle, random ack/err noise when idle.
    initial begin : slave
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                cnt = 0; ack_i = 1'b0; err_i = 1'b0; dat_i = 32'h0000_0000;
            end else if (!stb_o) begin
                cnt = 0;
                ack_i = 1'($urandom_range(0, 1));
                err_i = 1'($urandom_range(0, 1));
                dat_i = $urandom;
            end else begin
                cnt++;
                ack_i = 1'b0; err_i = 1'b0; dat_i = $urandom;
                if (cnt == a_k && a_kind != 3) begin
                    case (a_kind)
                        0: ack_i = 1'b1;
                        1: begin err_i = 1'b1; ack_i = 1'($urandom_range(0, 1)); end
                        default: begin err_i = 1'b1; ack_i = 1'b1; end
                    endcase
                    if (ack_i && !err_i) begin
                        if (we_o) begin
                            for (int b = 0; b < 4; b++) begin
                                if (sel_o[b]) s_mem[adr_o[3:0]][8*b +: 8] = dat_o[8*b +: 8];
                            end
                        end else begin
                            dat_i = s_mem[adr_o[3:0]];
                        end
                    end
                end
            end
        end
    end

    // Transaction-level model and per-cycle comparison of every DUT output.
    initial begin : compare
        bit          busy, seen, prev_stb, r_upd, r_err;
        int          t, len, low_run;
        logic        c_we;
        logic [15:0] c_adr;
        logic [31:0] c_dat, r_dat, m_rsp_dat;
        logic [7:0]  c_sel;
        logic        m_rsp_err;
        busy = 0; seen = 0; prev_stb = 0; r_upd = 0; r_err = 0;
        t = 0; len = 0; low_run = 0;
        c_we = 0; c_adr = 0; c_dat = 0; c_sel = 0; r_dat = 0;
        m_rsp_dat = 32'h0000_0000; m_rsp_err = 1'b0;
        forever begin
            @(posedge clk_i);
            if (!rst_ni) begin
                busy = 0; seen = 0; low_run = 0;
                m_rsp_dat = 32'h0000_0000; m_rsp_err = 1'b0;
            end else if (busy) begin
                t++;
                if (t > len + 1) busy = 0;
            end else if (cmd_valid_i) begin
                c_we = cmd_we_i; c_adr = cmd_adr_i; c_dat = cmd_dat_i;
                c_sel = cmd_sel_i & 8'h0F;
                a_kind = p_kind; a_k = p_k;
                if (p_kind != 3 && p_k <= TO) begin
                    len = p_k; r_err = (p_kind != 0);
                end else begin
                    len = TO; r_err = 1'b1;
                end
                r_upd = !r_err && !c_we;
                r_dat = m_mem[c_adr[3:0]];
                if (!r_err && c_we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (c_sel[b]) m_mem[c_adr[3:0]][8*b +: 8] = c_dat[8*b +: 8];
                    end
                end
                busy = 1; t = 1;
            end
            #1;
            if (busy && t == len + 1) begin
                m_rsp_err = r_err;
                if (r_upd) m_rsp_dat = r_dat;
            end
            chk("cmd_ready", cmd_ready_o, !busy);
            chk("rsp_valid", rsp_valid_o, busy && t == len + 1);
            chk("rsp_err", rsp_err_o, m_rsp_err);
            chk("rsp_dat", rsp_dat_o, m_rsp_dat);
            if (busy && t <= len) begin
                chk("cyc", cyc_o, 1'b1);
                chk("stb", stb_o, 1'b1);
                chk("we", we_o, c_we);
                chk("adr", adr_o, c_adr);
                chk("dat_o", dat_o, c_dat);
                chk("sel", sel_o, c_sel);
            end else begin
                chk("cyc_idle", cyc_o, 1'b0);
                chk("stb_idle", stb_o, 1'b0);
            end
            if (stb_o) begin
                if (!prev_stb && seen) chk("stb_gap_ge2", low_run >= 2, 1'b1);
                seen = 1; low_run = 0;
            end else begin
                low_run++;
            end
            prev_stb = stb_o;
        end
    end

    // Issue one command starting at a negedge; returns at the negedge of the response cycle.
    task automatic xact(input logic we, input logic [15:0] adr, input logic [31:0] dat,
                        input logic [7:0] sel, input int kind, input int k, input bit hold,
                        output logic [31:0] rdat, output logic rerr, output int stbc);
        bit accepted, done;
        cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = sel;
        p_kind = kind; p_k = k; cmd_valid_i = 1'b1;
        rdat = 32'h0; rerr = 1'b0; stbc = 0; accepted = 0; done = 0;
        for (int i = 0; i < 40 && !accepted; i++) begin
            if (cmd_ready_o) accepted = 1;
            else @(negedge clk_i);
        end
        chk("accept_wait", accepted, 1'b1);
        if (accepted) begin
            @(negedge clk_i);
            if (!hold) cmd_valid_i = 1'b0;
            for (int i = 0; i < 40 && !done; i++) begin
                if (stb_o) stbc++;
                if (rsp_valid_o) begin
                    done = 1; rdat = rsp_dat_o; rerr = rsp_err_o;
                end else begin
                    @(negedge clk_i);
                end
            end
            chk("rsp_wait", done, 1'b1);
        end
    endtask

    initial begin : driver
        logic [31:0] rdat;
        logic        rerr;
        int          stbc, kind, gap;
        bit          ok;
        for (int i = 0; i < 16; i++) begin
            s_mem[i] = 32'h0000_0000;
            m_mem[i] = 32'h0000_0000;
        end
        repeat (3) @(negedge clk_i);
        chk("rst_ready", cmd_ready_o, 1'b1);
        chk("rst_adr", adr_o, 16'h0000);
        chk("rst_dat", dat_o, 32'h0000_0000);
        chk("rst_sel", sel_o, 8'h00);
        chk("rst_we", we_o, 1'b0);
        #2 rst_ni = 1'b1;
        @(negedge clk_i);

        xact(1'b1, 16'h0010, 32'hDEADBEEF, 8'h0F, 0, 3, 1'b0, rdat, rerr, stbc);
        chk("wr_stb_cycles", stbc, 3);
        chk("wr_err", rerr, 1'b0);
        xact(1'b0, 16'h0010, 32'h0, 8'h0F, 0, 3, 1'b0, rdat, rerr, stbc);
        chk("rd_data", rdat, 32'hDEADBEEF);
        xact(1'b1, 16'h0010, 32'h11223344, 8'h03, 0, 2, 1'b0, rdat, rerr, stbc);
        xact(1'b0, 16'h0010, 32'h0, 8'h0F, 0, 1, 1'b0, rdat, rerr, stbc);
        chk("partial_rd", rdat, 32'hDEAD3344);
        xact(1'b0, 16'h0004, 32'h0, 8'h0F, 2, 2, 1'b0, rdat, rerr, stbc);
        chk("err_flag", rerr, 1'b1);
        chk("err_stb_cycles", stbc, 2);
        xact(1'b0, 16'h0008, 32'h0, 8'h0F, 3, 1, 1'b0, rdat, rerr, stbc);
        chk("to_stb_cycles", stbc, 4);
        chk("to_err", rerr, 1'b1);
        chk("to_ready_in_rsp", cmd_ready_o, 1'b0);
        @(negedge clk_i);
        chk("to_ready_after", cmd_ready_o, 1'b1);
        xact(1'b0, 16'h0010, 32'h0, 8'h0F, 0, 4, 1'b0, rdat, rerr, stbc);
        chk("late_ack_err", rerr, 1'b0);
        chk("late_ack_dat", rdat, 32'hDEAD3344);
        xact(1'b1, 16'h0025, 32'hCAFEF00D, 8'h0F, 0, 2, 1'b1, rdat, rerr, stbc);
        xact(1'b0, 16'h0025, 32'h0, 8'h0F, 0, 3, 1'b0, rdat, rerr, stbc);
        chk("b2b_rd", rdat, 32'hCAFEF00D);

        @(negedge clk_i);
        cmd_we_i = 1'b1; cmd_adr_i = 16'h0033; cmd_dat_i = 32'h5555AAAA; cmd_sel_i = 8'h0F;
        p_kind = 3; p_k = 1; cmd_valid_i = 1'b1;
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (cmd_ready_o) ok = 1;
            else @(negedge clk_i);
        end
        chk("rst_xact_accept", ok, 1'b1);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        @(negedge clk_i);
        chk("rst_pre_stb", stb_o, 1'b1);
        #2 rst_ni = 1'b0;
        #1;
        chk("rst_async_cyc", cyc_o, 1'b0);
        chk("rst_async_stb", stb_o, 1'b0);
        chk("rst_async_rsp", rsp_valid_o, 1'b0);
        @(negedge clk_i);
        #2 rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rst_release_ready", cmd_ready_o, 1'b1);
        chk("rst_release_rsp", rsp_valid_o, 1'b0);

        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 5) kind = 0;
            else if (kind == 6) kind = 1;
            else if (kind == 7) kind = 2;
            else kind = 3;
            gap = $urandom_range(0, 2);
            xact(1'($urandom_range(0, 1)), 16'($urandom), $urandom, 8'($urandom),
                 kind, $urandom_range(1, 5), 1'($urandom_range(0, 1)), rdat, rerr, stbc);
            if (gap > 0) begin
                cmd_valid_i = 1'b0;
                repeat (gap) @(negedge clk_i);
            end
        end
        cmd_valid_i = 1'b0;
        repeat (6) @(negedge clk_i);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
